// File: rtl/clk_seq_pkg.sv
// clk_src_sequencer shared types
// state encoding, command fields, helpers
package clk_seq_pkg;

  typedef enum logic [2:0] {
    IDLE,
    GATE,
    SWITCH,
    SETTLE,
    LOCK,
    UNGATE
  } state_t;

  localparam int SEL_BIT    = 0;
  localparam int SUBSEL_BIT = 1;
  localparam int RSVD_MSB   = 7;
  localparam int RSVD_LSB   = 2;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/clk_src_sequencer_timer.sv
// seq_timer: loadable down-counter
// holds at zero, never wraps
module seq_timer #(
  parameter int            TW      = 13,
  parameter logic [TW-1:0] RST_VAL = '0
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          i_load,
  input  logic [TW-1:0] i_val,
  output logic          o_zero
);

  logic [TW-1:0] r_cnt;

  // load on request, else count down to zero
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_cnt <= RST_VAL;
    end else if (i_load) begin
      r_cnt <= i_val;
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/clk_src_sequencer.sv
// clk_src_sequencer: glitch-safe clock
// source switch with gate/settle/lock
module clk_src_sequencer
  import clk_seq_pkg::*;
#(
  parameter int GATE_CYC   = 8,
  parameter int SETTLE_CYC = 16,
  parameter int LOCK_TO    = 4096
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic [7:0] cmd,
  input  logic       wcmd,
  input  logic       pll_locked,
  output logic       sel,
  output logic       subsel,
  output logic       clk_en,
  output logic       busy,
  output logic       ack,
  output logic       rej,
  output logic       err
);

  localparam int TW =
    $clog2(max3(GATE_CYC, SETTLE_CYC, LOCK_TO)) + 1;

  state_t        r_state;
  state_t        w_next;
  logic [1:0]    r_cmd;
  logic [1:0]    w_cmd;
  logic          r_sel;
  logic          r_subsel;
  logic          r_clk_en;
  logic          r_busy;
  logic          r_ack;
  logic          r_rej;
  logic          r_err;
  logic          w_sel;
  logic          w_subsel;
  logic          w_ack;
  logic          w_rej;
  logic          w_err;
  logic          w_load;
  logic [TW-1:0] w_val;
  logic          w_zero;
  logic          w_rsvd;
  logic          w_same;

  seq_timer #(
    .TW      (TW),
    .RST_VAL (TW'(LOCK_TO))
  ) u_timer (
    .CLK    (CLK),
    .RST    (RST),
    .i_load (w_load),
    .i_val  (w_val),
    .o_zero (w_zero)
  );

  assign w_rsvd = |cmd[RSVD_MSB:RSVD_LSB];
  assign w_same = (cmd[SEL_BIT] == r_sel) &&
                  (cmd[SUBSEL_BIT] == r_subsel);

  // next state, command decode, timer reload
  always_comb begin
    w_next   = r_state;
    w_cmd    = r_cmd;
    w_sel    = r_sel;
    w_subsel = r_subsel;
    w_ack    = 1'b0;
    w_rej    = 1'b0;
    w_err    = r_err;
    w_load   = 1'b0;
    w_val    = '0;
    unique case (r_state)
      IDLE: begin
        if (wcmd) begin
          if (w_rsvd) begin
            w_rej = 1'b1;
          end else begin
            w_ack = 1'b1;
            w_err = 1'b0;
            if (!w_same) begin
              w_cmd  = cmd[1:0];
              w_next = GATE;
            end
          end
        end
      end
      GATE: begin
        if (w_zero) begin
          w_next   = SWITCH;
          w_sel    = r_cmd[SEL_BIT];
          w_subsel = r_cmd[SUBSEL_BIT];
        end
      end
      SWITCH: w_next = SETTLE;
      SETTLE: begin
        if (w_zero) w_next = LOCK;
      end
      LOCK: begin
        if (r_sel || pll_locked) begin
          w_next = UNGATE;
        end else if (w_zero) begin
          w_err  = 1'b1;
          w_next = IDLE;
        end
      end
      UNGATE:  w_next = IDLE;
      default: w_next = IDLE;
    endcase
    if (wcmd && r_state != IDLE) w_rej = 1'b1;
    w_load = (w_next != r_state);
    unique case (w_next)
      GATE:    w_val = TW'(GATE_CYC - 1);
      SETTLE:  w_val = TW'(SETTLE_CYC - 1);
      LOCK:    w_val = TW'(LOCK_TO - 1);
      default: w_val = '0;
    endcase
  end

  // state and registered outputs
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state  <= LOCK;
      r_cmd    <= 2'b00;
      r_sel    <= 1'b0;
      r_subsel <= 1'b0;
      r_clk_en <= 1'b0;
      r_busy   <= 1'b1;
      r_ack    <= 1'b0;
      r_rej    <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_state  <= w_next;
      r_cmd    <= w_cmd;
      r_sel    <= w_sel;
      r_subsel <= w_subsel;
      r_clk_en <= (w_next == IDLE) && !w_err;
      r_busy   <= (w_next != IDLE);
      r_ack    <= w_ack;
      r_rej    <= w_rej;
      r_err    <= w_err;
    end
  end

  assign sel    = r_sel;
  assign subsel = r_subsel;
  assign clk_en = r_clk_en;
  assign busy   = r_busy;
  assign ack    = r_ack;
  assign rej    = r_rej;
  assign err    = r_err;

endmodule
